// File: rtl/mem_pkg.sv
// Shared types and constants for the load/store sequencer.
package mem_pkg;

  localparam int unsigned WORD_BYTES = 4;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    RESP  = 2'd3
  } state_t;

  // Legal funct3 for the direction, with natural alignment of the access.
  function automatic logic f3_legal(input logic we, input logic [2:0] f3,
                                    input logic [1:0] off);
    logic ok;
    case (f3)
      F3_B:    ok = 1'b1;
      F3_H:    ok = ~off[0];
      F3_W:    ok = (off == 2'b00);
      F3_BU:   ok = ~we;
      F3_HU:   ok = ~we & ~off[0];
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/lane_align.sv
// Byte-lane steering: store merge into an old word and load extract/extend.
import mem_pkg::*;

module lane_align (
  input  logic [31:0] old_word,
  input  logic [31:0] wdata,
  input  logic [1:0]  size,
  input  logic [1:0]  off,
  output logic [31:0] new_word,
  input  logic [31:0] rd_word,
  input  logic [2:0]  funct3,
  output logic [31:0] ld_data
);

  logic [1:0]  lane;
  logic [7:0]  byte_v;
  logic [15:0] half_v;

  // Store merge: replace only the addressed byte/halfword of the old word.
  always_comb begin
    new_word = old_word;
    lane     = '0;
    for (int unsigned i = 0; i < WORD_BYTES; i++) begin
      lane = 2'(i);
      case (size)
        2'b00:   if (lane == off) new_word[8*i +: 8] = wdata[7:0];
        2'b01:   if (lane[1] == off[1])
                   new_word[8*i +: 8] = lane[0] ? wdata[15:8] : wdata[7:0];
        default: new_word[8*i +: 8] = wdata[8*i +: 8];
      endcase
    end
  end

  // Load extract: pick the lane, then sign- or zero-extend by funct3.
  always_comb begin
    case (off)
      2'd0:    byte_v = rd_word[7:0];
      2'd1:    byte_v = rd_word[15:8];
      2'd2:    byte_v = rd_word[23:16];
      default: byte_v = rd_word[31:24];
    endcase
    half_v = off[1] ? rd_word[31:16] : rd_word[15:0];
    case (funct3)
      F3_B:    ld_data = {{24{byte_v[7]}}, byte_v};
      F3_H:    ld_data = {{16{half_v[15]}}, half_v};
      F3_BU:   ld_data = {24'h0, byte_v};
      F3_HU:   ld_data = {16'h0, half_v};
      default: ld_data = rd_word;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Multi-cycle load/store sequencer in front of a word-wide data RAM.
import mem_pkg::*;

module mem_access_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_we,
  input  logic [2:0]       req_funct3,
  input  logic [WIDTH-1:0] req_addr,
  input  logic [WIDTH-1:0] req_wdata,
  output logic             resp_valid,
  output logic [WIDTH-1:0] resp_rdata,
  output logic             resp_err,
  output logic             Data_WE,
  output logic [WIDTH-1:0] Data_addr,
  output logic [WIDTH-1:0] Data_WD,
  input  logic [WIDTH-1:0] Data_RD
);

  state_t           state;
  logic             we_q;
  logic [2:0]       f3_q;
  logic [WIDTH-1:0] addr_q;
  logic [WIDTH-1:0] wdata_q;
  logic [WIDTH-1:0] old_q;
  logic [WIDTH-1:0] merged;
  logic [WIDTH-1:0] ld_data;

  lane_align u_lane (
    .old_word (old_q),
    .wdata    (wdata_q),
    .size     (f3_q[1:0]),
    .off      (addr_q[1:0]),
    .new_word (merged),
    .rd_word  (Data_RD),
    .funct3   (f3_q),
    .ld_data  (ld_data)
  );

  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == RESP);
  assign Data_WE    = (state == WRITE);
  assign Data_addr  = {addr_q[WIDTH-1:2], 2'b00};
  assign Data_WD    = Data_WE ? merged : '0;

  // Sequencer: request capture, RAM read/write phases, registered response.
  // resp_rdata/resp_err only change on entry to RESP so they hold between responses.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      we_q       <= 1'b0;
      f3_q       <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      old_q      <= '0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            we_q    <= req_we;
            f3_q    <= req_funct3;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            if (!f3_legal(req_we, req_funct3, req_addr[1:0])) begin
              state      <= RESP;
              resp_err   <= 1'b1;
              resp_rdata <= '0;
            end else if (req_we && (req_funct3 == F3_W)) begin
              state <= WRITE;
            end else begin
              state <= READ;
            end
          end
        end
        READ: begin
          old_q <= Data_RD;
          if (we_q) begin
            state <= WRITE;
          end else begin
            state      <= RESP;
            resp_rdata <= ld_data;
            resp_err   <= 1'b0;
          end
        end
        WRITE: begin
          state      <= RESP;
          resp_rdata <= '0;
          resp_err   <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a small behavioural data RAM.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = '0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        Data_WE;
  logic [31:0] Data_addr;
  logic [31:0] Data_WD;
  logic [31:0] Data_RD;

  logic [31:0] mem [0:63];
  logic        poke_en = 1'b0;
  logic [5:0]  poke_idx = '0;
  logic [31:0] poke_val = '0;

  int passed = 0;
  int total  = 0;

  mem_access_unit #(.WIDTH(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .Data_WE    (Data_WE),
    .Data_addr  (Data_addr),
    .Data_WD    (Data_WD),
    .Data_RD    (Data_RD)
  );

  always #5 clk = ~clk;

  assign Data_RD = mem[Data_addr[7:2]];

  // RAM model: bench preload port, otherwise the DUT write port.
  always @(posedge clk) begin
    if (poke_en) mem[poke_idx] <= poke_val;
    else if (Data_WE) mem[Data_addr[7:2]] <= Data_WD;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  task automatic poke(input logic [5:0] idx, input logic [31:0] val);
    @(negedge clk);
    poke_en = 1'b1; poke_idx = idx; poke_val = val;
    @(negedge clk);
    poke_en = 1'b0;
  endtask

  // Issue one request, wait for acceptance, then follow it until resp_valid.
  // lat counts cycles after the accepting edge (1 = cycle right after it).
  task automatic do_op(input logic we, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wd_in,
                       output int lat, output logic [31:0] rdata, output logic err,
                       output int we_cnt, output int we_cyc, output logic [31:0] wd_seen,
                       output logic ready_seen, output int waits);
    lat = 0; rdata = '0; err = 1'b0; we_cnt = 0; we_cyc = 0;
    wd_seen = '0; ready_seen = 1'b0; waits = 0;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd_in;
    while (!req_ready && waits < 20) begin
      @(negedge clk);
      waits++;
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      if (req_ready) ready_seen = 1'b1;
      if (Data_WE) begin we_cnt++; we_cyc = c; wd_seen = Data_WD; end
      if (resp_valid) begin lat = c; rdata = resp_rdata; err = resp_err; break; end
      @(posedge clk); #1;
    end
  endtask

  int          lat, we_cnt, we_cyc, waits, rv_cnt, wen_cnt;
  logic [31:0] rdata, wd_seen;
  logic        err, ready_seen;

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready",  32'(req_ready),  32'd1);
    check("rst_rvalid", 32'(resp_valid), 32'd0);
    check("rst_rdata",  resp_rdata,      32'd0);
    check("rst_err",    32'(resp_err),   32'd0);
    check("rst_we",     32'(Data_WE),    32'd0);
    check("rst_addr",   Data_addr,       32'd0);
    check("rst_wd",     Data_WD,         32'd0);
    poke(6'd4,  32'hDEADBEEF);
    poke(6'd8,  32'h11223344);
    poke(6'd12, 32'hAABBCCDD);
    poke(6'd16, 32'h00000000);
    @(negedge clk);
    rst_n = 1'b1;

    // LW at 0x10
    do_op(1'b0, 3'b010, 32'h10, 32'h0, lat, rdata, err, we_cnt, we_cyc, wd_seen, ready_seen, waits);
    check("lw_lat",   32'(lat),    32'd2);
    check("lw_data",  rdata,       32'hDEADBEEF);
    check("lw_err",   32'(err),    32'd0);
    check("lw_nowe",  32'(we_cnt), 32'd0);

    // Sub-word loads from the same word
    do_op(1'b0, 3'b000, 32'h13, 32'h0, lat, rdata, err, we_cnt, we_cyc, wd_seen, ready_seen, waits);
    check("lb13",     rdata, 32'hFFFFFFDE);
    do_op(1'b0, 3'b100, 32'h13, 32'h0, lat, rdata, err, we_cnt, we_cyc, wd_seen, ready_seen, waits);
    check("lbu13",    rdata, 32'h000000DE);
    do_op(1'b0, 3'b001, 32'h12, 32'h0, lat, rdata, err, we_cnt, we_cyc, wd_seen, ready_seen, waits);
    check("lh12",     rdata, 32'hFFFFDEAD);
    check("lh12_lat", 32'(lat), 32'd2);
    do_op(1'b0, 3'b101, 32'h10, 32'h0, lat, rdata, err, we_cnt, we_cyc, wd_seen, ready_seen, waits);
    check("lhu10",    rdata, 32'h0000BEEF);
    do_op(1'b0, 3'b000, 32'h11, 32'h0, lat, rdata, err, we_cnt, we_cyc, wd_seen, ready_seen, waits);
    check("lb11",     rdata, 32'hFFFFFFBE);
    do_op(1'b0, 3'b100, 32'h10, 32'h0, lat, rdata, err, we_cnt, we_cyc, wd_seen, ready_seen, waits);
    check("lbu10",    rdata, 32'h000000EF);

    // SB 0x55 to 0x21 over 0x11223344
    do_op(1'b1, 3'b000, 32'h21, 32'hFFFFFF55, lat, rdata, err, we_cnt, we_cyc, wd_seen, ready_seen, waits);
    check("sb_lat",   32'(lat),    32'd3);
    check("sb_wecnt", 32'(we_cnt), 32'd1);
    check("sb_wecyc", 32'(we_cyc), 32'd2);
    check("sb_wd",    wd_seen,     32'h11225544);
    check("sb_rdata", rdata,       32'd0);
    check("sb_mem",   mem[8],      32'h11225544);

    // Misaligned SH and LW
    do_op(1'b1, 3'b001, 32'h23, 32'h00001234, lat, rdata, err, we_cnt, we_cyc, wd_seen, ready_seen, waits);
    check("sh23_lat",  32'(lat),    32'd1);
    check("sh23_err",  32'(err),    32'd1);
    check("sh23_data", rdata,       32'd0);
    check("sh23_nowe", 32'(we_cnt), 32'd0);
    check("sh23_mem",  mem[8],      32'h11225544);
    do_op(1'b0, 3'b010, 32'h22, 32'h0, lat, rdata, err, we_cnt, we_cyc, wd_seen, ready_seen, waits);
    check("lw22_lat",  32'(lat),    32'd1);
    check("lw22_err",  32'(err),    32'd1);
    check("lw22_data", rdata,       32'd0);

    // Illegal funct3 for each direction
    do_op(1'b0, 3'b011, 32'h20, 32'h0, lat, rdata, err, we_cnt, we_cyc, wd_seen, ready_seen, waits);
    check("ld011_err", 32'(err), 32'd1);
    do_op(1'b1, 3'b100, 32'h20, 32'h0, lat, rdata, err, we_cnt, we_cyc, wd_seen, ready_seen, waits);
    check("st100_err",  32'(err),    32'd1);
    check("st100_nowe", 32'(we_cnt), 32'd0);
    check("st100_mem",  mem[8],      32'h11225544);

    // Legal SH to the upper halfword
    do_op(1'b1, 3'b001, 32'h22, 32'h0000BEEF, lat, rdata, err, we_cnt, we_cyc, wd_seen, ready_seen, waits);
    check("sh22_lat", 32'(lat), 32'd3);
    check("sh22_err", 32'(err), 32'd0);
    check("sh22_mem", mem[8],   32'hBEEF5544);

    // SW then back-to-back LW
    do_op(1'b1, 3'b010, 32'h40, 32'hCAFEF00D, lat, rdata, err, we_cnt, we_cyc, wd_seen, ready_seen, waits);
    check("sw_lat",   32'(lat),        32'd2);
    check("sw_wecyc", 32'(we_cyc),     32'd1);
    check("sw_wd",    wd_seen,         32'hCAFEF00D);
    check("sw_busy",  32'(ready_seen), 32'd0);
    do_op(1'b0, 3'b010, 32'h40, 32'h0, lat, rdata, err, we_cnt, we_cyc, wd_seen, ready_seen, waits);
    check("b2b_wait", 32'(waits), 32'd1);
    check("b2b_lat",  32'(lat),   32'd2);
    check("b2b_data", rdata,      32'hCAFEF00D);

    // Reset during the READ phase of an SB
    repeat (2) @(negedge clk);
    check("pre_ready", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b000; req_addr = 32'h31; req_wdata = 32'h99;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("rd_nowe", 32'(Data_WE), 32'd0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("ar_ready",  32'(req_ready),  32'd1);
    check("ar_rvalid", 32'(resp_valid), 32'd0);
    check("ar_rdata",  resp_rdata,      32'd0);
    check("ar_err",    32'(resp_err),   32'd0);
    check("ar_we",     32'(Data_WE),    32'd0);
    check("ar_addr",   Data_addr,       32'd0);
    check("ar_wd",     Data_WD,         32'd0);
    rv_cnt = 0; wen_cnt = 0;
    for (int c = 0; c < 4; c++) begin
      if (resp_valid) rv_cnt++;
      if (Data_WE) wen_cnt++;
      @(posedge clk); #1;
    end
    check("ar_norsp", 32'(rv_cnt),  32'd0);
    check("ar_nowr",  32'(wen_cnt), 32'd0);
    check("ar_mem",   mem[12],      32'hAABBCCDD);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Multi-cycle load/store sequencer between the CPU datapath and `data_ram`. It accepts one RISC-V load or store request per handshake and issues word-aligned reads and writes to the byte-addressed data RAM. Sub-word stores (SB/SH) are done as read-modify-write, so the RAM's 4-byte write port never corrupts neighbouring bytes. Load data is lane-extracted and sign/zero-extended, and the result is returned on a one-cycle response strobe.

## Interface
- `WIDTH`, 32, data and address width; only 32 is supported.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: unit idle; a request is accepted when `req_valid & req_ready`.
- `req_we` in 1: 1 = store, 0 = load.
- `req_funct3` in 3: RISC-V funct3.
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
- `req_addr` in WIDTH: byte address.
- `req_wdata` in WIDTH: store data, right-aligned.
- `resp_valid` out 1: one-cycle completion strobe.
- `resp_rdata` out WIDTH: extended load data; 0 for stores and errors.
- `resp_err` out 1: misaligned access or illegal funct3; valid with `resp_valid`.
- `Data_WE` out 1: write enable to `data_ram`.
- `Data_addr` out WIDTH: word-aligned address to `data_ram`, `{addr[31:2],2'b00}`.
- `Data_WD` out WIDTH: write word to `data_ram`.
- `Data_RD` in WIDTH: combinational read word from `data_ram`.

## Operation
- States:
  - IDLE: `req_ready` = 1.
  - READ: captures `Data_RD`.
  - WRITE: `Data_WE` = 1.
  - RESP: `resp_valid` = 1.
- On accept, the unit registers `we`, `funct3`, `addr`, `wdata` and `off` = `addr[1:0]`.
- Legality check, done at accept:
  - LH, LHU, SH need `off[0]` = 0.
  - LW, SW need `off` = 0.
  - Any other funct3 value is illegal: loads 011, 110, 111; stores ≥ 011.
  - An illegal request goes IDLE→RESP with `resp_err` = 1 and performs no RAM write.
- Transitions for legal requests:
  - Load: IDLE→READ→RESP.
  - SW: IDLE→WRITE→RESP, with `Data_WD` = wdata.
  - SB/SH: IDLE→READ→WRITE→RESP.
- SB/SH merge: the write word is the old word with the byte at `off`, or the halfword at `off[1]`, replaced by `wdata[7:0]` / `wdata[15:0]`. All other bytes are unchanged.
- Load extract: select the byte at `off` or the halfword at `off[1]`. LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
- `Data_WE` is 1 only in WRITE. `Data_WD` is 0 outside WRITE.
- `resp_rdata` and `resp_err` are registered. They hold their values until the next RESP and read as 0 after reset.
- RESP→IDLE is unconditional; there is no response backpressure.
- Address bits above the RAM depth are passed through unchanged; range checking is not this block's job.

## Timing
- Accept at edge N. `resp_valid` is high during cycle:
  - error: N+1
  - load or SW: N+2
  - SB/SH: N+3
- `req_ready` is low from after the accepting edge until IDLE is re-entered. The earliest back-to-back accept is the edge ending RESP+1, so there is at most one request in flight.
- The RAM write commits on the edge that ends the WRITE cycle.
- Reset values: state IDLE, `req_ready` 1, `resp_valid` 0, `resp_rdata` 0, `resp_err` 0, `Data_WE` 0, `Data_addr` 0, `Data_WD` 0.
- Reset sampled in READ: the operation is aborted with no write and no response.
- Reset sampled in WRITE: the RAM write at that edge still occurs (WE is already asserted), but no response is given.
- `req_valid` held high while `req_ready` = 0 is ignored; the requester must hold the request until it is accepted.

## Structure
- Package `mem_pkg` holds:
  - `state_t` enum (IDLE, READ, WRITE, RESP);
  - funct3 localparams `F3_B`, `F3_H`, `F3_W`, `F3_BU`, `F3_HU`;
  - `WORD_BYTES` = 4.
- Sub-module `lane_align` (combinational) contains:
  - the store merge: old word, wdata, size, off → new word;
  - the load extract: word, funct3, off → extended data.
- The FSM and registers stay in `mem_access_unit`.

## Test plan
- LW at 0x10, RAM word 0xDEADBEEF → `resp_valid` at N+2; `resp_rdata` 0xDEADBEEF; `resp_err` 0; `Data_WE` never 1.
- LB at 0x13 and LBU at 0x13, same word → responses 0xFFFFFFDE and 0x000000DE. LH at 0x12 → 0xFFFFDEAD.
- SB 0x55 to 0x21, word 0x11223344 → one WE cycle at N+2 with `Data_WD` 0x11225544; `resp_valid` at N+3; RAM word becomes 0x11225544.
- SH at 0x23 and LW at 0x22 → `resp_err` = 1 at N+1, `resp_rdata` 0, no WE pulse, memory unchanged.
- SW 0xCAFEF00D to 0x40, then immediate LW at 0x40:
  - `req_ready` is low during the store;
  - the load is accepted right after RESP and returns 0xCAFEF00D.
- Reset pulsed (`rst_n` = 0) during READ of an SB → no WE, no `resp_valid`, and all outputs at their reset values on the next cycle.
